// File: rtl/sample_capture_buffer.sv
// Captures one sample_in word per qualified trigger rising edge into a circular buffer.
// Capture stops on the detector's stop pulse; a registered read port drains the buffer.
module sample_capture_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  address_enable,
   input  logic                  sample_trig,
   input  logic                  stop,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  clear,
   input  logic                  rd_req,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  frozen
);

   typedef enum logic [1:0] {IDLE, ARMED, FROZEN} state_t;

   state_t                  state;
   logic                    trig_q;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0]   rd_ptr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic capture;
   logic do_wr;
   logic do_rd;

   assign empty    = (count == '0);
   assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
   assign frozen   = (state == FROZEN);

   // Fullness is judged on the pre-edge count, so a read never frees a slot
   // for a capture in the same cycle.
   assign capture  = sample_trig & ~trig_q & address_enable & (state == ARMED);
   assign do_wr    = capture & ~full & ~clear;
   assign do_rd    = rd_req & ~empty & ~clear;

   always_ff @(posedge clk) begin
      if (resetb && do_wr)
         mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state    <= IDLE;
         trig_q   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (clear) begin
         // rd_data intentionally holds across a soft clear
         state    <= IDLE;
         trig_q   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         trig_q   <= sample_trig;
         rd_valid <= do_rd;
         if (do_rd) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (do_wr)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (capture && full)
            overflow <= 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
            default: count <= count;
         endcase
         case (state)
            IDLE:    if (address_enable) state <= ARMED;
            ARMED:   if (stop)           state <= FROZEN;
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Scoreboard bench for sample_capture_buffer: a queue model of the buffer predicts
// every read word, which is popped and compared when rd_valid appears.
module tb_sample_capture_buffer;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          resetb, address_enable, sample_trig, stop, clear, rd_req;
   logic [DW-1:0] sample_in;
   logic [DW-1:0] rd_data;
   logic          rd_valid, empty, full, overflow, frozen;
   logic [AW:0]   count;

   sample_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetb(resetb), .address_enable(address_enable),
      .sample_trig(sample_trig), .stop(stop), .sample_in(sample_in),
      .clear(clear), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .count(count), .empty(empty), .full(full), .overflow(overflow),
      .frozen(frozen)
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   // model state
   logic [DW-1:0] mdl[$];     // buffer contents, oldest first
   logic [DW-1:0] pend[$];    // words expected on the read port
   logic          mtrig = 1'b0;
   logic          movf  = 1'b0;
   logic [1:0]    mst   = 2'd0;   // 0 idle, 1 armed, 2 frozen
   logic [DW-1:0] mrd   = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict the effect of the upcoming edge from the driven inputs, clock it, compare.
   task automatic step();
      bit cap, rd;
      int sz;
      sz = mdl.size();
      rd = 0;
      if (!resetb || clear) begin
         mdl.delete();
         pend.delete();
         mst = 2'd0; mtrig = 1'b0; movf = 1'b0;
         if (!resetb) mrd = '0;
      end else begin
         cap = sample_trig && !mtrig && address_enable && mst == 2'd1;
         rd  = rd_req && sz != 0;
         if (rd) pend.push_back(mdl.pop_front());
         if (cap) begin
            if (sz < DEPTH) mdl.push_back(sample_in);
            else            movf = 1'b1;
         end
         if (mst == 2'd0 && address_enable) mst = 2'd1;
         else if (mst == 2'd1 && stop)      mst = 2'd2;
         mtrig = sample_trig;
      end
      @(posedge clk); #1;
      check("rd_valid", 32'(rd_valid), 32'(rd));
      if (rd) mrd = pend.pop_front();
      check("rd_data", 32'(rd_data), 32'(mrd));
      check("count", 32'(count), 32'(mdl.size()));
      check("empty", 32'(empty), 32'(mdl.size() == 0));
      check("full", 32'(full), 32'(mdl.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(movf));
      check("frozen", 32'(frozen), 32'(mst == 2'd2));
   endtask

   task automatic pulse(input logic [DW-1:0] d, input int hi, input int lo);
      sample_in = d; sample_trig = 1'b1;
      repeat (hi) step();
      sample_trig = 1'b0;
      repeat (lo) step();
   endtask

   task automatic drain(input int n);
      rd_req = 1'b1;
      repeat (n) step();
      rd_req = 1'b0;
      step();
   endtask

   initial begin
      resetb = 1'b0; address_enable = 1'b0; sample_trig = 1'b0; stop = 1'b0;
      clear = 1'b0; rd_req = 1'b0; sample_in = '0;
      #1;
      step();
      step();
      resetb = 1'b1;

      // edge while still IDLE is not captured
      address_enable = 1'b1; sample_trig = 1'b1; sample_in = 16'hdead;
      step();
      sample_trig = 1'b0;
      step();
      check("idle_edge_count", 32'(count), 32'd0);

      // basic capture and readout
      pulse(16'h0011, 3, 1);
      pulse(16'h0022, 3, 1);
      pulse(16'h0033, 3, 1);
      check("basic_count", 32'(count), 32'd3);
      drain(3);
      check("basic_empty", 32'(empty), 32'd1);
      // read while empty is ignored
      drain(2);

      // level-held trigger
      pulse(16'h0abc, 10, 1);
      check("level_count", 32'(count), 32'd1);
      drain(1);

      // full and overflow
      for (int i = 0; i < DEPTH + 2; i++) pulse(16'h0100 + 16'(i), 1, 1);
      check("full_flag", 32'(full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      // simultaneous read and edge while full: capture still dropped
      rd_req = 1'b1; sample_trig = 1'b1; sample_in = 16'hbeef;
      step();
      rd_req = 1'b0; sample_trig = 1'b0;
      step();
      drain(16);
      clear = 1'b1; step(); clear = 1'b0;
      step();

      // stop coincident with a capture edge
      pulse(16'h0201, 2, 1);
      pulse(16'h0202, 2, 1);
      sample_in = 16'h0203; sample_trig = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      sample_trig = 1'b0;
      step();
      check("stop_count", 32'(count), 32'd3);
      pulse(16'h0204, 1, 1);
      pulse(16'h0205, 1, 1);
      check("frozen_count", 32'(count), 32'd3);
      drain(1);
      clear = 1'b1; step(); clear = 1'b0;
      check("clear_count", 32'(count), 32'd0);
      step();

      // simultaneous capture/read across pointer wrap
      for (int i = 0; i < 15; i++) pulse(16'h0300 + 16'(i), 1, 1);
      for (int i = 0; i < 20; i++) begin
         rd_req = 1'b1; sample_trig = 1'b1; sample_in = 16'h0400 + 16'(i);
         step();
         rd_req = 1'b0; sample_trig = 1'b0;
         step();
      end
      check("wrap_count", 32'(count), 32'd15);
      drain(15);

      // reset mid-operation, then a reset glitch between edges
      for (int i = 0; i < 5; i++) pulse(16'h0500 + 16'(i), 1, 1);
      rd_req = 1'b1; resetb = 1'b0;
      step();
      rd_req = 1'b0; resetb = 1'b1;
      check("rst_count", 32'(count), 32'd0);
      step();
      for (int i = 0; i < 3; i++) pulse(16'h0600 + 16'(i), 1, 1);
      resetb = 1'b0; #2; resetb = 1'b1;
      step();
      check("glitch_count", 32'(count), 32'd3);
      drain(3);

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         sample_trig    = 1'($urandom_range(0, 1));
         sample_in      = 16'($urandom);
         rd_req         = ($urandom_range(0, 3) == 0);
         address_enable = ($urandom_range(0, 7) != 0);
         stop           = ($urandom_range(0, 99) == 0);
         clear          = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/sample_capture_buffer.md
# sample_capture_buffer

Downstream consumer of the sample edge detector. Qualifies its `sample_trig_out` level with `address_enable` and captures one `sample_in` word per trigger rising edge into a circular buffer of DEPTH entries. Stops writing when the detector's `stop` pulse arrives. Exposes a one-word-per-request read port so the readout/scan logic can drain captured oscillator samples.

## Interface
- `DATA_WIDTH`, default 16: width of `sample_in` and `rd_data`.
- `DEPTH`, default 16: buffer entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default $clog2(DEPTH): pointer width.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `resetb`  in  1: reset, synchronous, active-low.
- `address_enable`  in  1: from the edge detector; capture is permitted only while high.
- `sample_trig`  in  1: edge detector `sample_trig_out`; a level, typically high 2–3 cycles per event.
- `stop`  in  1: edge detector stop pulse; freezes capture.
- `sample_in`  in  DATA_WIDTH: word sampled on a trigger edge.
- `clear`  in  1: synchronous soft clear; returns to IDLE, empties the buffer.
- `rd_req`  in  1: read request; honoured only when `empty`=0.
- `rd_data`  out  DATA_WIDTH: read word, registered.
- `rd_valid`  out  1: one-cycle strobe qualifying `rd_data`.
- `count`  out  ADDR_WIDTH+1: entries held, 0..DEPTH.
- `empty`, `full`  out  1: count==0 / count==DEPTH.
- `overflow`  out  1: sticky; a capture was dropped because the buffer was full.
- `frozen`  out  1: high in FROZEN state.

## Operation
- FSM states: IDLE, ARMED, FROZEN.
  - IDLE → ARMED when `address_enable`=1.
  - ARMED → FROZEN on `stop`=1.
  - FROZEN → IDLE on `clear`.
  - `clear` from any state → IDLE.
  - ARMED is not left if `address_enable` drops; captures are simply gated.
- Trigger edge: `trig_q` registers `sample_trig`. A capture event is `sample_trig & ~trig_q & address_enable & (state==ARMED)`.
  - Exactly one capture per rising edge, regardless of how long the level is held.
- Capture:
  - If not full, write `sample_in` (value at the edge cycle) to `mem[wr_ptr]` and increment `wr_ptr` modulo DEPTH.
  - If full, drop the word and set `overflow`; pointers and count are unchanged.
- Read:
  - If `rd_req` & !`empty`, `rd_data` <= `mem[rd_ptr]`, `rd_valid` <= 1, and `rd_ptr` increments modulo DEPTH.
  - `rd_req` while empty is ignored: `rd_valid` stays 0 and `rd_data` holds.
- Reads are allowed in every state, including FROZEN.
- Simultaneous capture and read:
  - Both are performed and `count` is unchanged.
  - When full, the read frees no slot in the same cycle, so the capture is still dropped.
  - When empty, the read is ignored and the capture proceeds.
- `stop` in the same cycle as a capture event: the capture is performed, then the state becomes FROZEN.
- `clear` or reset: `wr_ptr`, `rd_ptr`, `count`, `overflow`, `trig_q`, `rd_valid` go to 0 and the state to IDLE. Memory contents are not cleared.
  - `clear` has priority over simultaneous capture and read.
- Pointer and count arithmetic is unsigned. Pointers wrap naturally at ADDR_WIDTH bits. `count` is never allowed to exceed DEPTH or fall below 0.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `frozen`=0, state IDLE.
- Reset is sampled on the clk edge only; no asynchronous path.
- Capture latency: trigger rising edge seen at cycle N → `count`/`full`/`empty` update at N+1.
- Read latency: `rd_req` at cycle N → `rd_data` and `rd_valid` valid at N+1 for exactly one cycle. Back-to-back `rd_req` gives one word per cycle.
- `stop` at cycle N → `frozen`=1 at N+1. A trigger edge at N+1 or later is not captured.
- `address_enable` at N → ARMED at N+1. A trigger edge at N is not captured because the state is still IDLE.
- `overflow` asserts at N+1 after the dropped edge and holds until `clear` or reset.

## Test plan
- **Basic capture and readout:** reset; `address_enable`=1; 3 trigger pulses, each 3 cycles high, with `sample_in`=0x0011, 0x0022, 0x0033 → `count`=3. Three `rd_req` → `rd_data` 0x0011, 0x0022, 0x0033 with `rd_valid` on each, then `empty`=1.
- **Level-held trigger:** `sample_trig` held high 10 cycles → exactly one capture, `count`=1.
- **Full and overflow:** DEPTH+2 trigger edges with no reads → `count`=16, `full`=1, `overflow`=1. Reading 16 words returns the first 16 values in order.
- **Stop/freeze:** capture 2 words; assert `stop` coincident with a third edge → `count`=3, `frozen`=1. Further edges leave `count`=3. `clear` → `count`=0, IDLE.
- **Simultaneous capture/read and wrap:** preload 15 entries; hold `rd_req` high while issuing 20 more edges → `count` stays 15, data order preserved across pointer wrap, `overflow`=0.
- **Reset mid-operation:** `resetb`=0 for one cycle with `count`=5 and `rd_req` high → next cycle `count`=0, `rd_valid`=0, `empty`=1, state IDLE. Asserting `resetb` low between clock edges has no effect until the next edge.
